truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Sequential stimulus/capture stage wrapped around a 4-input combinational logic function such as s = x.~w + y.~w.~z + x.y.~z.
- Drives the function's inputs through all 2^N_IN combinations in ascending order and samples the function's output for each one.
- Assembles the captured truth table, counts ones and compares each entry against an expected minterm mask.
- Replaces the hand-written #1 stimulus lists with a self-checking hardware sweep that reports pass/fail.

Parameters:
- N_IN, 4, number of function inputs; vector width.
- EXPECTED, 16'h7310, expected truth table; bit i = required output for input index i. Default is minterms 4, 8, 9, 12, 13, 14.
- SETTLE, 1, wait cycles (>=1) between driving a vector and sampling f_in.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE or DONE.
- f_in  input  1  output of the function under check.
- vec_out  output  N_IN  input vector to the function; bit order {x,y,w,z}, x is the MSB.
- busy  output  1  high while sweeping (WAIT/SAMPLE).
- done  output  1  level, high in DONE.
- pass  output  1  high in DONE when err_count==0; 0 elsewhere.
- table_out  output  2^N_IN  captured truth table; bit i = f_in sampled for index i.
- ones_count  output  N_IN+1  number of 1s captured so far.
- err_count  output  N_IN+1  number of mismatches against EXPECTED.
- first_err_idx  output  N_IN  index of the first mismatch; 0 while err_count==0.

Behaviour:
- Reset:
  - Synchronous, active-high, one clock, overrides everything including mid-sweep.
  - State -> IDLE.
  - vec_out=0, busy=0, done=0, pass=0, table_out=0, ones_count=0, err_count=0, first_err_idx=0.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 -> clear all result registers, vec_out=0, settle counter=0, go to WAIT.
- WAIT:
  - busy=1; vec_out held stable.
  - Settle counter increments each cycle.
  - After SETTLE cycles in WAIT, go to SAMPLE.
- SAMPLE (one cycle):
  - table_out[vec_out] <= f_in.
  - ones_count += f_in.
  - If f_in != EXPECTED[vec_out]: err_count += 1. If err_count was 0, first_err_idx <= vec_out.
  - If vec_out == 2^N_IN-1 -> DONE. Otherwise vec_out += 1, settle counter = 0, go to WAIT.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - vec_out stays at 2^N_IN-1; results held.
  - start=1 -> same action as in IDLE: clear results, go to WAIT, done drops on that edge.
- start handling:
  - Ignored while busy; no restart, no effect on results.
  - start held high continuously re-launches a sweep each time DONE is reached, one cycle after done rises.
- Timing:
  - Number the edge that accepts start as edge 0.
  - Vector k is sampled on edge (k+1)*(SETTLE+1).
  - done rises on edge 2^N_IN*(SETTLE+1): edge 32 for defaults.
  - Each vector is presented for exactly SETTLE+1 cycles.
- Width rules:
  - Counters are sized N_IN+1 so that a value of 16 does not wrap.
  - vec_out never wraps; the sweep ends at all-ones.
- Simultaneous rst and start: rst wins; result is IDLE.
- All outputs are registered; none depend combinationally on f_in.

Test Plan:
- Bench connects vec_out to a model of s = x.~w + y.~w.~z + x.y.~z, pulses start (defaults) -> done=1 at edge 32, pass=1, table_out=16'h7310, ones_count=6, err_count=0, first_err_idx=0.
- f_in tied 0, start -> table_out=0, ones_count=0, err_count=6, first_err_idx=4, pass=0, done=1.
- f_in tied 1, start -> table_out=16'hFFFF, ones_count=16 (no wrap), err_count=10, first_err_idx=0, pass=0.
- Correct model, rst asserted one cycle while vec_out=7 -> next edge: all outputs 0, state IDLE. New start -> full correct sweep, pass=1.
- start pulsed again at vec_out=3 mid-sweep -> ignored: sweep completes at edge 32, pass=1. Then start in DONE -> done=0 on that edge, results cleared, second sweep ends with pass=1.
- SETTLE=3 with correct model -> each vector held 4 cycles, done rises at edge 64, table_out=16'h7310, pass=1.

Source files
------------

// File: rtl/truth_table_checker.sv
// Sweeps every input combination of an N_IN-input combinational function,
// captures its truth table and compares it against the EXPECTED minterm mask.
module truth_table_checker #(
    parameter int                      N_IN     = 4,
    parameter logic [(1<<N_IN)-1:0]    EXPECTED = 16'h7310,
    parameter int                      SETTLE   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   f_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          ones_count,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_err_idx,
    output logic [1:0]             state_dbg
);

    localparam int              CNT_W       = N_IN + 1;
    localparam int              SW          = $clog2(SETTLE + 1);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SW-1:0]      settle_cnt;
    logic               mismatch;
    logic [CNT_W-1:0]   err_next;
    logic               last_vec;

    assign state_dbg = state_q;

    // Handshake: start is a level request, accepted only on an edge where the
    // checker is IDLE or DONE; it is ignored while busy.
    always_comb begin
        mismatch = (f_in != EXPECTED[vec_out]);
        err_next = err_count + CNT_W'(mismatch);
        last_vec = (vec_out == VEC_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (settle_cnt == SETTLE_LAST) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                state_d = last_vec ? S_DONE : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out       <= '0;
            settle_cnt    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            table_out     <= '0;
            ones_count    <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec_out       <= '0;
                        settle_cnt    <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        table_out     <= '0;
                        ones_count    <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                    end
                end
                S_WAIT: begin
                    if (settle_cnt != SETTLE_LAST) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    table_out[vec_out] <= f_in;
                    ones_count         <= ones_count + CNT_W'(f_in);
                    err_count          <= err_next;
                    if (mismatch && (err_count == '0)) begin
                        first_err_idx <= vec_out;
                    end
                    // The last vector is left on vec_out so the sweep never wraps.
                    if (last_vec) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_next == '0);
                    end else begin
                        vec_out    <= vec_out + 1'b1;
                        settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: function models and random tables drive f_in,
// and expected results are derived per index from the function definition.
module tb_truth_table_checker;

    localparam int          NV  = 16;
    localparam logic [15:0] EXP = 16'h7310;

    logic        clk = 1'b0;
    logic        rst, start, start3;
    logic        f_in, f_in3;
    logic [3:0]  vec_out, vec_out3, first_err_idx, first_err_idx3;
    logic        busy, done, pass, busy3, done3, pass3;
    logic [15:0] table_out, table_out3;
    logic [4:0]  ones_count, err_count, ones_count3, err_count3;
    logic [1:0]  state_dbg, state_dbg3;

    int          f_mode;     // 0 model, 1 tied 0, 2 tied 1, 3 random table
    logic [15:0] rand_tab;
    int          sel;        // 1 selects dut, 3 selects dut3
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] exp_tab;
    int          exp_ones, exp_err, exp_first;

    logic        s_busy, s_done, s_pass;
    logic [3:0]  s_vec, s_first;
    logic [15:0] s_tab;
    logic [4:0]  s_ones, s_err;
    logic [1:0]  s_state;

    always #5 clk = ~clk;

    truth_table_checker #(.N_IN(4), .EXPECTED(16'h7310), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .f_in(f_in), .vec_out(vec_out),
        .busy(busy), .done(done), .pass(pass), .table_out(table_out),
        .ones_count(ones_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .state_dbg(state_dbg)
    );

    truth_table_checker #(.N_IN(4), .EXPECTED(16'h7310), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .f_in(f_in3), .vec_out(vec_out3),
        .busy(busy3), .done(done3), .pass(pass3), .table_out(table_out3),
        .ones_count(ones_count3), .err_count(err_count3),
        .first_err_idx(first_err_idx3), .state_dbg(state_dbg3)
    );

    // s = x.~w + y.~w.~z + x.y.~z with index bits {x,y,w,z}
    function automatic logic model_s(input logic [3:0] v);
        logic x, y, w, z;
        {x, y, w, z} = v;
        return (x & ~w) | (y & ~w & ~z) | (x & y & ~z);
    endfunction

    function automatic logic f_of(input int mode, input logic [3:0] v);
        case (mode)
            0:       return model_s(v);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return rand_tab[v];
        endcase
    endfunction

    always_comb begin
        f_in  = f_of(f_mode, vec_out);
        f_in3 = model_s(vec_out3);
    end

    always_comb begin
        if (sel == 3) begin
            s_busy = busy3; s_done = done3; s_pass = pass3; s_vec = vec_out3;
            s_first = first_err_idx3; s_tab = table_out3; s_ones = ones_count3;
            s_err = err_count3; s_state = state_dbg3;
        end else begin
            s_busy = busy; s_done = done; s_pass = pass; s_vec = vec_out;
            s_first = first_err_idx; s_tab = table_out; s_ones = ones_count;
            s_err = err_count; s_state = state_dbg;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic build_expected(input int mode);
        logic b;
        exp_tab = '0; exp_ones = 0; exp_err = 0; exp_first = 0;
        for (int i = 0; i < NV; i++) begin
            b = (mode == 9) ? model_s(4'(i)) : f_of(mode, 4'(i));
            exp_tab[i] = b;
            exp_ones += int'(b);
            if (b != EXP[i]) begin
                if (exp_err == 0) exp_first = i;
                exp_err++;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vec"},   32'(s_vec), 0);
        check({tag, "_busy"},  32'(s_busy), 0);
        check({tag, "_done"},  32'(s_done), 0);
        check({tag, "_pass"},  32'(s_pass), 0);
        check({tag, "_tab"},   32'(s_tab), 0);
        check({tag, "_ones"},  32'(s_ones), 0);
        check({tag, "_err"},   32'(s_err), 0);
        check({tag, "_first"}, 32'(s_first), 0);
        check({tag, "_state"}, 32'(s_state), 0);
    endtask

    // Launch a sweep on the selected DUT; optionally re-pulse start when vec_out hits poke_vec.
    task automatic sweep(input string tag, input int settle, input int poke_vec);
        int done_edge, bad, ev;
        bit poked;
        @(negedge clk);
        if (sel == 3) start3 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start3 = 1'b0;
        check({tag, "_acc_busy"}, 32'(s_busy), 1);
        check({tag, "_acc_done"}, 32'(s_done), 0);
        check({tag, "_acc_tab"},  32'(s_tab), 0);
        check({tag, "_acc_err"},  32'(s_err), 0);
        done_edge = -1; bad = 0; poked = 0;
        for (int n = 1; n < NV * (settle + 1) + 20; n++) begin
            @(negedge clk);
            ev = n / (settle + 1);
            if (ev > NV - 1) ev = NV - 1;
            if (32'(s_vec) != 32'(ev)) bad++;
            if (s_done) begin
                done_edge = n;
                break;
            end
            if (poke_vec >= 0 && !poked && 32'(s_vec) == 32'(poke_vec)) begin
                start = 1'b1;
                poked = 1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_done_edge"}, 32'(done_edge), 32'(NV * (settle + 1)));
        check({tag, "_vec_seq"},   32'(bad), 0);
        check({tag, "_tab"},   32'(s_tab), 32'(exp_tab));
        check({tag, "_ones"},  32'(s_ones), 32'(exp_ones));
        check({tag, "_err"},   32'(s_err), 32'(exp_err));
        check({tag, "_first"}, 32'(s_first), 32'(exp_first));
        check({tag, "_pass"},  32'(s_pass), 32'(exp_err == 0));
        check({tag, "_busy"},  32'(s_busy), 0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; start3 = 1'b0; sel = 1; f_mode = 0; rand_tab = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        sel = 3;
        check_zero("reset3");
        sel = 1;
        rst = 1'b0;

        f_mode = 0; build_expected(0);
        check("model_table", 32'(exp_tab), 32'(EXP));
        sweep("model", 1, -1);

        f_mode = 1; build_expected(1);
        sweep("tie0", 1, -1);

        f_mode = 2; build_expected(2);
        sweep("tie1", 1, -1);

        // Reset mid-sweep at vector 7
        f_mode = 0; build_expected(0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        while (vec_out != 4'd7 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_wait_timeout", 32'(cnt < 100), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        sweep("after_rst", 1, -1);

        // Start re-pulsed mid-sweep is ignored; then restart from DONE
        sweep("poke", 1, 3);
        sweep("from_done", 1, -1);

        sel = 3; build_expected(9);
        sweep("settle3", 3, -1);
        sel = 1;

        for (int r = 0; r < 6; r++) begin
            f_mode = 3;
            rand_tab = 16'($urandom_range(0, 16'hFFFF));
            if (r == 0) rand_tab = EXP ^ 16'h8000;
            build_expected(3);
            sweep($sformatf("rand%0d", r), 1, (r % 2 == 1) ? int'($urandom_range(0, 14)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
